unified_mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipelined CPU.
- Grants one requester at a time and drives the memory handshake.
- Returns read data to the granted requester and generates per-requester stall signals that freeze the PC and pipeline registers.
- Data is prioritised over fetch, with a starvation guard for fetch and a watchdog timeout for memory responses.

---
 rtl/unified_mem_arbiter_if.sv | 25 ++
 rtl/unified_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified memory arbiter.
// The arbiter (master) drives the request, write enable, address and write data.
// The memory (slave) returns read data and a one-cycle mem_ack.
//   mem_req   : access in flight
//   mem_we    : 1 = store, 0 = load/fetch
//   mem_addr  : byte address of the access
//   mem_wdata : store data
//   mem_rdata : read data, valid while mem_ack=1
//   mem_ack   : one-cycle completion strobe
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// instruction fetch (IF) and data (MEM) stages of the pipeline.
// Data wins over fetch, except when fetch has waited behind MAX_DATA_STREAK
// consecutive data grants. A watchdog aborts an access that sees no mem_ack
// within TIMEOUT busy cycles and raises a sticky error.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_if_req/i_if_addr  : fetch request (held until o_if_valid), byte address
//   o_if_rdata/o_if_valid/o_if_stall : fetched word, done pulse, stall
//   i_d_rd/i_d_wr/i_d_addr/i_d_wdata : load/store request and operands
//   o_d_rdata/o_d_valid/o_d_stall    : load data, done pulse, stall
//   mem                 : memory bus (master side)
//   o_err               : sticky timeout flag
module unified_mem_arbiter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_d_rd,
  input  logic              i_d_wr,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_d_stall,
  unified_mem_arbiter_if.master mem,
  output logic              o_err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [2:0] {S_IDLE, S_BUSY_IF, S_BUSY_D, S_DONE_IF, S_DONE_D} state_t;

  state_t            r_state, w_state_nxt;
  logic [ST_W-1:0]   r_streak;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_sel;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [31:0]       r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid, r_d_valid, r_err;

  logic w_d_req, w_force_if, w_grant_d, w_to_hit;

  always_comb begin
    w_d_req    = i_d_rd | i_d_wr;
    w_force_if = i_if_req && (r_streak == ST_W'(MAX_DATA_STREAK));
    w_grant_d  = (r_state == S_IDLE) && w_d_req && !w_force_if;
    // Current busy cycle is the TIMEOUT-th one; abort unless ack arrives now.
    w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d)     w_state_nxt = S_BUSY_D;
        else if (i_if_req) w_state_nxt = S_BUSY_IF;
      end
      S_BUSY_IF: if (mem.mem_ack || w_to_hit) w_state_nxt = S_DONE_IF;
      S_BUSY_D:  if (mem.mem_ack || w_to_hit) w_state_nxt = S_DONE_D;
      default:   w_state_nxt = S_IDLE;  // DONE states never grant
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak    <= '0;
      r_to_cnt    <= '0;
      r_sel       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_req  <= (w_state_nxt == S_BUSY_IF) || (w_state_nxt == S_BUSY_D);
      r_if_valid <= (w_state_nxt == S_DONE_IF);
      r_d_valid  <= (w_state_nxt == S_DONE_D);
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_grant_d) begin
            r_mem_addr  <= i_d_addr;
            r_mem_wdata <= i_d_wdata;
            r_mem_we    <= i_d_wr;  // rd+wr together behaves as a store
            if (!i_if_req)                              r_streak <= '0;
            else if (r_streak != ST_W'(MAX_DATA_STREAK)) r_streak <= r_streak + ST_W'(1);
          end else if (i_if_req) begin
            r_mem_addr <= i_if_addr;
            r_mem_we   <= 1'b0;
            r_sel      <= i_if_addr[2];
            r_streak   <= '0;
          end
        end
        S_BUSY_IF: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (mem.mem_ack) begin
            r_if_rdata <= r_sel ? mem.mem_rdata[63:32] : mem.mem_rdata[31:0];
          end else if (w_to_hit) begin
            r_if_rdata <= '0;
            r_err      <= 1'b1;
          end
        end
        S_BUSY_D: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (mem.mem_ack) begin
            if (!r_mem_we) r_d_rdata <= mem.mem_rdata;
          end else if (w_to_hit) begin
            r_d_rdata <= '0;
            r_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign o_if_rdata    = r_if_rdata;
  assign o_if_valid    = r_if_valid;
  assign o_d_rdata     = r_d_rdata;
  assign o_d_valid     = r_d_valid;
  assign o_err         = r_err;
  // Stalls are combinational so the pipeline freezes in the request cycle.
  assign o_if_stall    = i_if_req & ~r_if_valid;
  assign o_d_stall     = w_d_req & ~r_d_valid;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int AW = 64, DW = 64, MDS = 4, TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req, if_valid, if_stall;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_rd, d_wr, d_valid, d_stall, err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MDS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
    .o_if_valid(if_valid), .o_if_stall(if_stall),
    .i_d_rd(d_rd), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_valid(d_valid), .o_d_stall(d_stall),
    .mem(mif), .o_err(err)
  );

  // memory model: acks on the mem_lat-th busy cycle (mem_lat=0: never)
  logic [63:0] mdata;
  int          mem_lat;
  int          busy_cnt;
  logic        r_mack, inj_ack;
  assign mif.mem_rdata = mdata;
  assign mif.mem_ack   = r_mack | inj_ack;

  always @(negedge clk) begin
    if (reset || !mif.mem_req) begin
      busy_cnt <= 0;
      r_mack   <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt + 1;
      r_mack   <= (mem_lat != 0) && (busy_cnt + 1 == mem_lat);
    end
  end

  int n_chk = 0, n_fail = 0, n_if = 0, n_d = 0;
  logic [31:0] exp_if[$];
  logic [63:0] exp_d[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one cycle; sample at negedge and drain the scoreboard on completions
  task automatic cyc();
    @(negedge clk);
    if (if_valid) begin
      chk("if_q_nonempty", 64'(exp_if.size() != 0), 64'd1);
      if (exp_if.size() != 0) chk("if_rdata", 64'(if_rdata), 64'(exp_if.pop_front()));
      n_if++;
    end
    if (d_valid) begin
      chk("d_q_nonempty", 64'(exp_d.size() != 0), 64'd1);
      if (exp_d.size() != 0) chk("d_rdata", d_rdata, exp_d.pop_front());
      n_d++;
    end
  endtask

  task automatic wait_d(input int budget);
    int n0 = n_d;
    for (int i = 0; i < budget && n_d == n0; i++) cyc();
    chk("d_wait", 64'(n_d - n0), 64'd1);
  endtask

  task automatic wait_if(input int budget);
    int n0 = n_if;
    for (int i = 0; i < budget && n_if == n0; i++) cyc();
    chk("if_wait", 64'(n_if - n0), 64'd1);
  endtask

  initial begin
    int n0d, n0i;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mdata = '0; mem_lat = 0; inj_ack = 1'b0;
    repeat (3) cyc();
    chk("rst_mem_req", 64'(mif.mem_req), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_addr", mif.mem_addr, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    reset = 1'b0;
    cyc();

    // reset during the second BUSY_D cycle, then a stray ack
    d_rd = 1'b1; d_addr = 64'h200;
    cyc();
    chk("rmid_busy_req", 64'(mif.mem_req), 64'd1);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rmid_req", 64'(mif.mem_req), 64'd0);
    chk("rmid_d_valid", 64'(d_valid), 64'd0);
    chk("rmid_err", 64'(err), 64'd0);
    chk("rmid_addr", mif.mem_addr, 64'd0);
    reset = 1'b0; d_rd = 1'b0; inj_ack = 1'b1;
    cyc();
    inj_ack = 1'b0;
    chk("rmid_ack_valid", 64'(d_valid), 64'd0);
    chk("rmid_ack_req", 64'(mif.mem_req), 64'd0);
    cyc();
    chk("rmid_ack_valid2", 64'(d_valid), 64'd0);

    // single fetch, upper half
    mdata = 64'hAABBCCDD_11223344; mem_lat = 3;
    if_req = 1'b1; if_addr = 64'h104; exp_if.push_back(32'hAABBCCDD);
    #1 chk("fetch_stall_c0", 64'(if_stall), 64'd1);
    n0i = n_if;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("fetch_req", 64'(mif.mem_req), 64'(c <= 3));
      chk("fetch_stall", 64'(if_stall), 64'(c <= 3));
      chk("fetch_valid", 64'(if_valid), 64'(c == 4));
      if (c == 1) chk("fetch_addr", mif.mem_addr, 64'h104);
    end
    chk("fetch_count", 64'(n_if - n0i), 64'd1);
    if_req = 1'b0;
    cyc();

    // starvation guard: 4 data grants, then fetch despite d_rd
    mdata = 64'h11111111_22222222; mem_lat = 1;
    if_req = 1'b1; if_addr = 64'h504; d_rd = 1'b1; d_addr = 64'h600;
    repeat (4) exp_d.push_back(64'h11111111_22222222);
    exp_if.push_back(32'h11111111);
    n0d = n_d; n0i = n_if;
    for (int i = 0; i < 100 && n_if == n0i; i++) cyc();
    chk("starve_if_done", 64'(n_if - n0i), 64'd1);
    chk("starve_d_grants", 64'(n_d - n0d), 64'd4);
    chk("starve_if_addr", mif.mem_addr, 64'h504);
    chk("starve_d_stall", 64'(d_stall), 64'd1);
    if_req = 1'b0;
    exp_d.push_back(64'h11111111_22222222);
    wait_d(20);
    d_rd = 1'b0;
    cyc();

    // collision: data first, fetch in the IDLE after DONE_D
    mdata = 64'h5; mem_lat = 2;
    if_req = 1'b1; if_addr = 64'h300; d_rd = 1'b1; d_addr = 64'h40;
    exp_d.push_back(64'h5); exp_if.push_back(32'h5);
    n0i = n_if;
    cyc();
    chk("col_first_addr", mif.mem_addr, 64'h40);
    chk("col_first_we", 64'(mif.mem_we), 64'd0);
    wait_d(20);
    chk("col_if_pending", 64'(n_if - n0i), 64'd0);
    d_rd = 1'b0;
    cyc();
    chk("col_idle_req", 64'(mif.mem_req), 64'd0);
    cyc();
    chk("col_if_req", 64'(mif.mem_req), 64'd1);
    chk("col_if_addr", mif.mem_addr, 64'h300);
    wait_if(20);
    if_req = 1'b0;
    cyc();

    // store: d_rdata unchanged (still the last load value)
    mem_lat = 3;
    d_wr = 1'b1; d_addr = 64'h80; d_wdata = 64'hDEAD;
    exp_d.push_back(64'h5);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk("st_req", 64'(mif.mem_req), 64'd1);
      chk("st_we", 64'(mif.mem_we), 64'd1);
      chk("st_addr", mif.mem_addr, 64'h80);
      chk("st_wdata", mif.mem_wdata, 64'hDEAD);
      chk("st_valid_early", 64'(d_valid), 64'd0);
    end
    cyc();
    chk("st_valid", 64'(d_valid), 64'd1);
    d_wr = 1'b0;
    cyc();

    // timeout: no ack ever
    mem_lat = 0; mdata = 64'hFFFF_FFFF_FFFF_FFFF;
    d_rd = 1'b1; d_addr = 64'h700;
    exp_d.push_back(64'h0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("to_req", 64'(mif.mem_req), 64'd1);
      chk("to_err_early", 64'(err), 64'd0);
    end
    cyc();
    chk("to_valid", 64'(d_valid), 64'd1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_req_off", 64'(mif.mem_req), 64'd0);
    d_rd = 1'b0;
    cyc();
    mem_lat = 2; if_req = 1'b1; if_addr = 64'h8;
    exp_if.push_back(32'hFFFFFFFF);
    wait_if(20);
    chk("to_err_sticky", 64'(err), 64'd1);
    if_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    chk("to_err_clr", 64'(err), 64'd0);
    reset = 1'b0;
    cyc();

    chk("sb_if_empty", 64'(exp_if.size()), 64'd0);
    chk("sb_d_empty", 64'(exp_d.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
